alu_arbiter: RTL and testbench

Shares one 16-bit combinational ALU between two requesters. Each request carries A, B, Cin and Mode. The block:
- arbitrates round-robin;
- registers the winning operands onto the shared ALU inputs;
- captures Y/Cout/Overflow one cycle later;
- returns the result with the requester ID over a valid/ready response port.

It sits between the requester-side datapath logic and the ALU instance.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 16-bit combinational ALU
// between two requesters. Each op takes 3 cycles: IDLE, EXEC, RESP.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           request handshake, ready only in IDLE
//   reqN_a/b/cin/mode          request operands
//   reqN_lock                  keep the grant for the next op
//                              (used only when ALU_ARB_LOCK_EN is defined)
//   alu_a/b/cin/mode           registered operands to the ALU
//   alu_y/cout/overflow        ALU result, captured in EXEC
//   rsp_valid/ready            response handshake
//   rsp_id/y/cout/overflow     requester index, result, masked flags
module alu_arbiter #(
   parameter int N = 16,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req0_cin,
   input  logic [M-1:0] req0_mode,
   input  logic         req0_lock,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic         req1_cin,
   input  logic [M-1:0] req1_mode,
   input  logic         req1_lock,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic         alu_cin,
   output logic [M-1:0] alu_mode,
   input  logic [N-1:0] alu_y,
   input  logic         alu_cout,
   input  logic         alu_overflow,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_y,
   output logic         rsp_cout,
   output logic         rsp_overflow
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   rr_gnt;
   logic   gnt;
   logic   accept;
   logic   flags_en;

   // Tie goes to the port that did not win last time.
   assign rr_gnt = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

`ifdef ALU_ARB_LOCK_EN
   logic lock_q;
   logic lock_hit;

   // A held lock always belongs to the last granted port.
   assign lock_hit = lock_q && (last_grant ? req1_valid : req0_valid);
   assign gnt      = lock_hit ? last_grant : rr_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= 1'b0;
      end else if (accept) begin
         lock_q <= gnt ? req1_lock : req0_lock;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = req0_lock ^ req1_lock;
   assign gnt         = rr_gnt;
`endif

   // Flags are meaningful only for the add/subtract modes.
   assign flags_en = (alu_mode[M-1:1] == 3'b010);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = (state == RESP);
      unique case (state)
         IDLE: begin
            // rst_n gating keeps ready low while reset is held.
            if (rst_n && (req0_valid || req1_valid)) begin
               accept     = 1'b1;
               req0_ready = ~gnt;
               req1_ready = gnt;
               state_nxt  = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant   <= 1'b1;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_cin      <= 1'b0;
         alu_mode     <= '0;
         rsp_id       <= 1'b0;
         rsp_y        <= '0;
         rsp_cout     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else begin
         if (accept) begin
            last_grant <= gnt;
            rsp_id     <= gnt;
            alu_a      <= gnt ? req1_a : req0_a;
            alu_b      <= gnt ? req1_b : req0_b;
            alu_cin    <= gnt ? req1_cin : req0_cin;
            alu_mode   <= gnt ? req1_mode : req0_mode;
         end
         if (state == EXEC) begin
            rsp_y        <= alu_y;
            rsp_cout     <= flags_en & alu_cout;
            rsp_overflow <= flags_en & alu_overflow;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter,
// with a small behavioural ALU driving alu_y/cout/overflow.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_cin, req0_lock;
   logic [15:0] req0_a, req0_b;
   logic [3:0]  req0_mode;
   logic        req1_valid, req1_ready, req1_cin, req1_lock;
   logic [15:0] req1_a, req1_b;
   logic [3:0]  req1_mode;
   logic [15:0] alu_a, alu_b, alu_y;
   logic        alu_cin, alu_cout, alu_overflow;
   logic [3:0]  alu_mode;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_overflow;
   logic [15:0] rsp_y;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req0_mode(req0_mode), .req0_lock(req0_lock),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .req1_mode(req1_mode), .req1_lock(req1_lock),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_mode(alu_mode), .alu_y(alu_y), .alu_cout(alu_cout),
      .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow)
   );

   // Add (0100), subtract (0101); any other mode XORs and forces
   // both flags high so masking is visible.
   logic [15:0] bb;
   logic [16:0] sum;
   always_comb begin
      bb           = (alu_mode == 4'b0101) ? ~alu_b : alu_b;
      sum          = {1'b0, alu_a} + {1'b0, bb} + {16'b0, alu_cin};
      alu_y        = sum[15:0];
      alu_cout     = sum[16];
      alu_overflow = (alu_a[15] == bb[15]) && (sum[15] != alu_a[15]);
      if (alu_mode != 4'b0100 && alu_mode != 4'b0101) begin
         alu_y        = alu_a ^ alu_b;
         alu_cout     = 1'b1;
         alu_overflow = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_lock  = 1'b0;
      req1_lock  = 1'b0;
      rsp_ready  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Starts and ends at a negedge with the DUT in IDLE.
   task automatic do_op(input logic p, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic [3:0] mode, input logic [15:0] ey,
                        input logic ec, input logic eo);
      if (p) begin
         req1_a = a; req1_b = b; req1_cin = cin; req1_mode = mode;
         req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_cin = cin; req0_mode = mode;
         req0_valid = 1'b1;
      end
      #1;
      chk("op_ready", 32'({req1_ready, req0_ready}),
          p ? 32'd2 : 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("op_exec_valid", 32'(rsp_valid), 32'd0);
      chk("op_alu_a", 32'(alu_a), 32'(a));
      chk("op_alu_mode", 32'(alu_mode), 32'(mode));
      @(negedge clk);
      chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("op_rsp_id", 32'(rsp_id), 32'(p));
      chk("op_rsp_y", 32'(rsp_y), 32'(ey));
      chk("op_rsp_cout", 32'(rsp_cout), 32'(ec));
      chk("op_rsp_ovf", 32'(rsp_overflow), 32'(eo));
      @(negedge clk);
      chk("op_done", 32'(rsp_valid), 32'd0);
   endtask

   logic [3:0] got;
   logic [3:0] exp_lock;
   int         cyc [4];
   int         n;
   logic [15:0] held_y;

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_mode = '0;
      req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_mode = '0;
      req0_lock = 1'b0; req1_lock = 1'b0;
      rsp_ready = 1'b1;
      #2;
      chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b}), 32'd0);
      chk("rst_alu_cm", 32'({alu_cin, alu_mode}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_cout, rsp_overflow}),
          32'd0);
      chk("rst_rsp_y", 32'(rsp_y), 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Directed single ops, including the flag mask case.
      do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 4'b0100,
            16'h8000, 1'b0, 1'b1);
      do_op(1'b1, 16'h00F0, 16'h0FF0, 1'b0, 4'b0000,
            16'h0F00, 1'b0, 1'b0);
      do_op(1'b0, 16'h0005, 16'h0003, 1'b1, 4'b0101,
            16'h0002, 1'b1, 1'b0);
      do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 4'b0100,
            16'h0000, 1'b1, 1'b0);
      do_op(1'b0, 16'h1234, 16'h00FF, 1'b1, 4'b0011,
            16'h12CB, 1'b0, 1'b0);

      // Round-robin with both valid from reset.
      do_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      n = 0; got = '0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            chk("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
            got[n] = req1_ready;
            cyc[n] = c;
            n++;
         end
         @(negedge clk);
      end
      chk("rr_count", 32'(n), 32'd4);
      chk("rr_order", 32'(got), 32'b1010);
      for (int i = 1; i < 4; i++) begin
         chk("rr_spacing", 32'(cyc[i] - cyc[i-1]), 32'd3);
      end

      // Backpressure: hold RESP for 5 cycles.
      do_reset();
      req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
      req0_mode = 4'b0100;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      held_y = rsp_y;
      chk("bp_y", 32'(held_y), 32'h0003);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_stable", 32'({rsp_id, rsp_y, rsp_cout, rsp_overflow}),
             32'({1'b0, held_y, 2'b00}));
         chk("bp_ready", 32'({req1_ready, req0_ready}), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_next_grant", 32'({req1_ready, req0_ready}), 32'd2);

      // Reset in the middle of EXEC.
      do_reset();
      req0_a = 16'h1234; req0_b = 16'h1111; req0_cin = 1'b1;
      req0_mode = 4'b0101;
      req0_valid = 1'b1;
      @(negedge clk);
      req1_valid = 1'b1;
      chk("mid_in_exec", 32'(alu_a), 32'h1234);
      rst_n = 1'b0;
      #1;
      chk("mid_alu", 32'({alu_a, alu_b}), 32'd0);
      chk("mid_alu_cm", 32'({alu_cin, alu_mode}), 32'd0);
      chk("mid_rsp", 32'({rsp_valid, rsp_id, rsp_cout, rsp_overflow}),
          32'd0);
      chk("mid_ready", 32'({req1_ready, req0_ready}), 32'd0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("mid_tie", 32'({req1_ready, req0_ready}), 32'd1);

      // Lock: req0 asks to keep the grant for its first two ops.
      do_reset();
      req0_valid = 1'b1; req1_valid = 1'b1;
      n = 0; got = '0;
`ifdef ALU_ARB_LOCK_EN
      exp_lock = 4'b1000;
`else
      exp_lock = 4'b1010;
`endif
      for (int c = 0; c < 20 && n < 4; c++) begin
         req0_lock = (n < 2);
         #1;
         if (req0_ready || req1_ready) begin
            got[n] = req1_ready;
            n++;
         end
         @(negedge clk);
      end
      chk("lock_count", 32'(n), 32'd4);
      chk("lock_order", 32'(got), 32'(exp_lock));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
